// File: rtl/spart_rx_fifo.sv
// ============================================================================
//  Module   : spart_rx_fifo
//  Brief    : SPART receive byte FIFO with bus data/status read port.
//             Optional registered level/overrun interrupt: SPART_RX_FIFO_IRQ_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spart_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int IRQ_THRESH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rda,
    input  logic [7:0] rx_data,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    output logic [7:0] bus_dout,
    output logic       bus_dvalid,
`ifdef SPART_RX_FIFO_IRQ_EN
    output logic       irq,
`endif
    output logic       rda
);

    localparam int                    c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_FULL    = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    logic [7:0]            mem_q [0:c_DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovr_q, ovr_d;
    logic [7:0]            bus_dout_q, bus_dout_d;
    logic                  bus_dvalid_q, bus_dvalid_d;
    logic                  rx_rda_q;

    logic                  w_full;
    logic                  w_rda;
    logic                  w_push;
    logic                  w_pop_req;
    logic                  w_pop;
    logic                  w_stat;
    logic                  w_wr_en;
    logic                  w_ovr_set;
    logic [DEPTH_LOG2:0]   w_inc;
    logic [DEPTH_LOG2:0]   w_dec;

    assign w_full    = (count_q == c_FULL);
    assign w_rda     = (count_q != '0);
    assign w_push    = rx_rda & ~rx_rda_q;
    assign w_pop_req = iocs & iorw & (ioaddr == 2'b00);
    assign w_pop     = w_pop_req & w_rda;
    assign w_stat    = iocs & iorw & (ioaddr == 2'b01);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_wr_en   = w_push & (~w_full | w_pop);
    assign w_ovr_set = w_push & w_full & ~w_pop;
    assign w_inc     = {{DEPTH_LOG2{1'b0}}, w_wr_en};
    assign w_dec     = {{DEPTH_LOG2{1'b0}}, w_pop};

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + w_inc - w_dec;
        ovr_d        = ovr_q;
        bus_dout_d   = bus_dout_q;
        bus_dvalid_d = w_pop_req | w_stat;

        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end

        if (w_pop_req) begin
            bus_dout_d = w_pop ? mem_q[rd_ptr_q] : 8'h00;
        end else if (w_stat) begin
            bus_dout_d = {ovr_q, w_full, w_rda, 1'b0, 4'(count_q)};
        end

        // Overrun set takes priority over the clear-on-status-read.
        if (w_ovr_set) begin
            ovr_d = 1'b1;
        end else if (w_stat) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovr_q        <= 1'b0;
            bus_dout_q   <= 8'h00;
            bus_dvalid_q <= 1'b0;
            rx_rda_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovr_q        <= ovr_d;
            bus_dout_q   <= bus_dout_d;
            bus_dvalid_q <= bus_dvalid_d;
            rx_rda_q     <= rx_rda;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

`ifdef SPART_RX_FIFO_IRQ_EN
    localparam logic [DEPTH_LOG2:0] c_IRQ_THRESH = (DEPTH_LOG2+1)'(IRQ_THRESH);

    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (count_q >= c_IRQ_THRESH) | ovr_q;
        end
    end

    assign irq = irq_q;
`endif

    assign bus_dout   = bus_dout_q;
    assign bus_dvalid = bus_dvalid_q;
    assign rda        = w_rda;

endmodule

`default_nettype wire

// File: tb/tb_spart_rx_fifo.sv
// ============================================================================
//  Module   : tb_spart_rx_fifo
//  Brief    : Directed self-checking bench for spart_rx_fifo (DEPTH_LOG2=3).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rx_rda;
    logic [7:0] rx_data;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] bus_dout;
    logic       bus_dvalid;
    logic       rda;
`ifdef SPART_RX_FIFO_IRQ_EN
    logic       irq;
`endif

    int n_total;
    int n_bad;

    spart_rx_fifo #(
        .DEPTH_LOG2 (3),
        .IRQ_THRESH (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rda     (rx_rda),
        .rx_data    (rx_data),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .bus_dout   (bus_dout),
        .bus_dvalid (bus_dvalid),
`ifdef SPART_RX_FIFO_IRQ_EN
        .irq        (irq),
`endif
        .rda        (rda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data = b;
        rx_rda  = 1'b1;
        tick();
        rx_rda  = 1'b0;
        tick();
    endtask

    // One-cycle read strobe; data and dvalid are sampled one clock later.
    task automatic rd(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = addr;
        tick();
        iocs   = 1'b0;
        check({tag, "_dv"}, 32'(bus_dvalid), 32'd1);
        check(tag, 32'(bus_dout), 32'(exp));
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        rx_rda  = 1'b0;
        rx_data = 8'h00;
        iocs    = 1'b0;
        iorw    = 1'b0;
        ioaddr  = 2'b00;
        tick();
        tick();
        check("rst_rda", 32'(rda), 32'd0);
        check("rst_dout", 32'(bus_dout), 32'h00);
        check("rst_dv", 32'(bus_dvalid), 32'd0);
        rst = 1'b0;
        tick();

        // Single byte round trip
        push(8'hA5);
        check("one_rda", 32'(rda), 32'd1);
        rd("one_data", 2'b00, 8'hA5);
        check("one_rda_after", 32'(rda), 32'd0);
        tick();
        check("dv_drop", 32'(bus_dvalid), 32'd0);

        // Writes are ignored
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00;
        tick();
        iocs = 1'b0;
        check("write_ign_dv", 32'(bus_dvalid), 32'd0);

        // Fill to full, drain in order
        for (int i = 1; i <= 8; i++) push(8'(i));
        rd("full_stat", 2'b01, 8'h68);
        for (int i = 1; i <= 8; i++) rd("drain", 2'b00, 8'(i));
        rd("empty_stat", 2'b01, 8'h00);
        push(8'h99);
        rd("wrap_data", 2'b00, 8'h99);

        // Overrun: dropped byte, sticky flag cleared by status read
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        push(8'hFF);
        rd("ovr_stat1", 2'b01, 8'hE8);
        rd("ovr_stat2", 2'b01, 8'h68);

        // Simultaneous push and pop while full
        rx_data = 8'h55;
        rx_rda  = 1'b1;
        iocs    = 1'b1;
        iorw    = 1'b1;
        ioaddr  = 2'b00;
        tick();
        iocs    = 1'b0;
        rx_rda  = 1'b0;
        check("simul_dv", 32'(bus_dvalid), 32'd1);
        check("simul_data", 32'(bus_dout), 32'h11);
        tick();
        rd("simul_stat", 2'b01, 8'h68);
        for (int i = 1; i < 8; i++) rd("simul_drain", 2'b00, 8'h11 + 8'(i));
        rd("simul_last", 2'b00, 8'h55);

        // Level held high pushes once; empty read returns zero
        rx_data = 8'h77;
        rx_rda  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rx_rda  = 1'b0;
        tick();
        rd("hold_stat", 2'b01, 8'h21);
        rd("hold_data", 2'b00, 8'h77);
        rd("under_data", 2'b00, 8'h00);
        rd("under_stat", 2'b01, 8'h00);

        // Reset with 3 queued and ovr set
        for (int i = 0; i < 9; i++) push(8'hC0 + 8'(i));
        for (int i = 0; i < 5; i++) rd("pre_rst_pop", 2'b00, 8'hC0 + 8'(i));
        check("pre_rst_rda", 32'(rda), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rda", 32'(rda), 32'd0);
        check("mid_rst_dout", 32'(bus_dout), 32'h00);
        rd("post_rst_stat", 2'b01, 8'h00);
        push(8'h3C);
        rd("post_rst_data", 2'b00, 8'h3C);

`ifdef SPART_RX_FIFO_IRQ_EN
        for (int i = 0; i < 3; i++) push(8'(i));
        check("irq_lo3", 32'(irq), 32'd0);
        rx_data = 8'h03;
        rx_rda  = 1'b1;
        tick();
        rx_rda  = 1'b0;
        check("irq_edge", 32'(irq), 32'd0);
        tick();
        check("irq_hi", 32'(irq), 32'd1);
        rd("irq_pop", 2'b00, 8'h00);
        check("irq_hold", 32'(irq), 32'd1);
        tick();
        check("irq_fall", 32'(irq), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spart_rx_fifo.md
Name: spart_rx_fifo

Overview:
- Receive buffer directly downstream of the SPART receiver.
- Captures each completed byte the receiver flags with its ready strobe and queues it in a small circular FIFO.
- Serves the processor bus: data pops from address 00, a status byte from address 01.
- Decouples the CPU read timing from serial arrival, so back-to-back frames are not lost while software is busy.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth. Legal range 1..3 (2..8 entries).
- IRQ_THRESH, 4, fill level at/above which irq asserts. Used only with SPART_RX_FIFO_IRQ_EN. Legal 1..2**DEPTH_LOG2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx_rda  input  1  receiver ready flag; a 0->1 transition marks a new byte.
- rx_data  input  8  receiver shift-register byte; valid whenever rx_rda is high.
- iocs  input  1  chip select from bus.
- iorw  input  1  1 = read, 0 = write. Writes are ignored by this block.
- ioaddr  input  2  00 = data (IO_XFER), 01 = status; 10/11 ignored.
- bus_dout  output  8  registered read data.
- bus_dvalid  output  1  one-cycle pulse, bus_dout valid.
- rda  output  1  FIFO not empty.
- irq  output  1  present only with SPART_RX_FIFO_IRQ_EN.

Behaviour:
- Reset (rst=1 at a posedge) sets wr_ptr=0, rd_ptr=0, count=0, ovr=0, bus_dout=8'h00, bus_dvalid=0, rx_rda_d=0. rda is therefore 0 and irq is 0.
- Reset mid-frame or mid-read discards all queued data. The next rising edge of rx_rda after reset is captured normally.
- Push event: rx_rda & ~rx_rda_d, where rx_rda_d is rx_rda registered once. A level held high pushes exactly once.
- Pop event: iocs & iorw & ioaddr==00 & count!=0.
- Status read: iocs & iorw & ioaddr==01.
- Pointers are DEPTH_LOG2 bits and wrap naturally from 2**DEPTH_LOG2-1 to 0.
- count is DEPTH_LOG2+1 bits.
- Push when not full: mem[wr_ptr] <= rx_data; wr_ptr++; count++.
- Push when full with no simultaneous pop: byte dropped, pointers unchanged, ovr <= 1 (sticky).
- Pop: bus_dout <= mem[rd_ptr]; rd_ptr++; count--; bus_dvalid=1 next cycle. Latency is 1 clk from strobe to data.
- Simultaneous push and pop, including when full: both take effect and count is unchanged. No overrun when full because the pop frees a slot the same cycle. Pop returns the old head.
- Data read when empty: bus_dout <= 8'h00, bus_dvalid pulses, pointers and count unchanged (underflow ignored, no flag).
- Status read: bus_dout <= {ovr, full, rda, 1'b0, count zero-extended to 4 bits}, bus_dvalid pulses. ovr clears on this read.
- If an overrun occurs in the same cycle as a status read, set wins: ovr stays 1, and the returned byte shows the pre-edge ovr value.
- Reads held for multiple cycles pop once per cycle. The bus master must strobe for one cycle per access.
- rda = (count != 0); full = (count == 2**DEPTH_LOG2). Both are combinational from registered count.

Optional Feature:
- Macro SPART_RX_FIFO_IRQ_EN.
- Defined: irq port exists; irq is registered, 1 in the cycle after count >= IRQ_THRESH or ovr==1, and 0 otherwise.
- Undefined: irq port and its logic are absent. IRQ_THRESH is unused. All other behaviour is identical.

Test Plan:
- Reset, then pulse rx_rda with rx_data=8'hA5, then a data read -> rda=1 after push; bus_dout=8'hA5 with bus_dvalid one clk after strobe; rda=0 afterwards.
- Push 8'h01..8'h08 (DEPTH_LOG2=3), then status read -> bus_dout=8'h68 (full=1, rda=1, count=8). Eight data reads return 01..08 in order. Pointers wrap, and a 9th push stores at index 0.
- Fill to 8, push 8'hFF -> byte dropped. Status read returns 8'hE8 (ovr=1). A second status read returns 8'h68.
- Full FIFO with push 8'h55 and data read in the same cycle -> read returns the oldest byte, count stays 8, ovr stays 0, and 8'h55 is last out.
- Hold rx_rda high for 5 cycles -> exactly one push (count=1). Data read on an empty FIFO returns 8'h00 with count unchanged.
- Assert rst with 3 bytes queued and ovr set -> next-cycle rda=0, bus_dout=8'h00, and status read returns 8'h00. With SPART_RX_FIFO_IRQ_EN and IRQ_THRESH=4, irq rises one clk after the 4th push and falls one clk after the pop to 3.
